// File: rtl/nonce_sweeper.sv
// Nonce sweeper: loads a block header byte-wise, appends a nonce and launches the sha256 core once per
// nonce until a hash below target is found or the nonce space runs out. Define NONCE_SWEEPER_BSWAP_EN to byte-reverse the nonce field.
module nonce_sweeper #(
   parameter int HDR_BYTES = 76,
   parameter int NONCE_W   = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   input  logic                          hdr_clear,
   input  logic [NONCE_W-1:0]            nonce_init,
   input  logic [255:0]                  target,
   input  logic                          start,
   input  logic                          abort,
   output logic                          core_rst_n,
   output logic [HDR_BYTES*8+NONCE_W-1:0] core_block,
   input  logic [255:0]                  core_hash,
   input  logic                          core_done,
   output logic                          busy,
   output logic                          found,
   output logic                          exhausted,
   output logic [NONCE_W-1:0]            found_nonce,
   output logic [31:0]                   attempts
);

   localparam int HDR_W = HDR_BYTES * 8;
   localparam int CNT_W = $clog2(HDR_BYTES + 1);

   typedef enum logic [2:0] {
      S_LOAD,
      S_READY,
      S_LAUNCH,
      S_WAIT,
      S_CHECK,
      S_FOUND,
      S_EXHAUST
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   byte_cnt;
   logic [HDR_W-1:0]   header_q;
   logic [NONCE_W-1:0] nonce_q;
   logic [NONCE_W-1:0] nonce_field;
   logic [255:0]       target_q;
   logic [255:0]       hash_q;
   logic               first_wait;
   logic               last_byte;
   logic               done_ok;
   logic               hit;
   logic               nonce_max;

   assign last_byte = (byte_cnt == CNT_W'(HDR_BYTES - 1));
   // A done left over from the previous launch is never trusted on the first WAIT cycle.
   assign done_ok   = core_done && !first_wait;
   assign hit       = (hash_q < target_q);
   assign nonce_max = &nonce_q;

`ifdef NONCE_SWEEPER_BSWAP_EN
   always_comb begin
      nonce_field = '0;
      for (int i = 0; i < NONCE_W / 8; i++) begin
         nonce_field[8*i +: 8] = nonce_q[NONCE_W-1-8*i -: 8];
      end
   end
`else
   assign nonce_field = nonce_q;
`endif

   assign core_block = {header_q, nonce_field};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      busy       = 1'b0;
      found      = 1'b0;
      exhausted  = 1'b0;
      core_rst_n = 1'b0;
      case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
            if (!hdr_clear && in_valid && last_byte) begin
               state_d = S_READY;
            end
         end
         S_READY, S_FOUND, S_EXHAUST: begin
            found     = (state_q == S_FOUND);
            exhausted = (state_q == S_EXHAUST);
            if (hdr_clear) begin
               state_d = S_LOAD;
            end else if (start) begin
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            busy    = 1'b1;
            state_d = abort ? S_READY : S_WAIT;
         end
         S_WAIT: begin
            busy       = 1'b1;
            core_rst_n = 1'b1;
            if (abort) begin
               state_d = S_READY;
            end else if (done_ok) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            busy       = 1'b1;
            core_rst_n = 1'b1;
            if (abort) begin
               state_d = S_READY;
            end else if (hit) begin
               state_d = S_FOUND;
            end else if (nonce_max) begin
               state_d = S_EXHAUST;
            end else begin
               state_d = S_LAUNCH;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   // Datapath: nonce only moves on the CHECK->LAUNCH edge, so core_block is stable for a whole attempt.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt    <= '0;
         header_q    <= '0;
         nonce_q     <= '0;
         target_q    <= '0;
         hash_q      <= '0;
         first_wait  <= 1'b0;
         found_nonce <= '0;
         attempts    <= '0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (hdr_clear) begin
                  byte_cnt <= '0;
               end else if (in_valid) begin
                  header_q[HDR_W-1-8*int'(byte_cnt) -: 8] <= in_data;
                  byte_cnt <= byte_cnt + CNT_W'(1);
               end
            end
            S_READY, S_FOUND, S_EXHAUST: begin
               if (hdr_clear) begin
                  byte_cnt <= '0;
               end else if (start) begin
                  nonce_q  <= nonce_init;
                  target_q <= target;
                  attempts <= '0;
               end
            end
            S_LAUNCH: begin
               first_wait <= 1'b1;
            end
            S_WAIT: begin
               first_wait <= 1'b0;
               if (!abort && done_ok) begin
                  hash_q <= core_hash;
               end
            end
            S_CHECK: begin
               if (!abort) begin
                  if (attempts != 32'hFFFF_FFFF) begin
                     attempts <= attempts + 32'd1;
                  end
                  if (hit) begin
                     found_nonce <= nonce_q;
                  end else if (!nonce_max) begin
                     nonce_q <= nonce_q + NONCE_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nonce_sweeper.sv
// Directed bench for nonce_sweeper with a behavioural core whose hash is the bitwise inverse of the nonce.
// Expected sweep results come from a reference loop and are queued on start, checked when the sweep ends.
module tb_nonce_sweeper;

   localparam int LAT = 5;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, hdr_clear, start, abort;
   logic [7:0]   in_data;
   logic [31:0]  nonce_init, found_nonce, attempts;
   logic [255:0] target, core_hash;
   logic         core_rst_n, core_done, busy, found, exhausted;
   logic [639:0] core_block;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        fnd;
      logic        exh;
      logic [31:0] nonce;
      logic [31:0] att;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   nonce_sweeper dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .hdr_clear(hdr_clear), .nonce_init(nonce_init), .target(target), .start(start),
      .abort(abort), .core_rst_n(core_rst_n), .core_block(core_block), .core_hash(core_hash),
      .core_done(core_done), .busy(busy), .found(found), .exhausted(exhausted),
      .found_nonce(found_nonce), .attempts(attempts)
   );

   function automatic logic [31:0] blockNonce(input logic [31:0] w);
`ifdef NONCE_SWEEPER_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   function automatic logic [255:0] modelHash(input logic [31:0] n);
      return {224'h0, ~n};
   endfunction

   function automatic exp_t predict(input logic [31:0] init, input logic [255:0] tgt);
      exp_t        e;
      logic [31:0] n;
      e.fnd = 1'b0; e.exh = 1'b0; e.nonce = 32'h0; e.att = 32'h0;
      n = init;
      for (int i = 0; i < 64; i++) begin
         e.att = e.att + 32'd1;
         if (modelHash(n) < tgt) begin
            e.fnd = 1'b1; e.nonce = n;
            return e;
         end
         if (n == 32'hFFFF_FFFF) begin
            e.exh = 1'b1;
            return e;
         end
         n = n + 32'd1;
      end
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural core: fixed latency after reset release, done held until the next reset.
   logic [639:0] launchBlock;
   int           coreCnt;
   always @(posedge clk) begin
      if (!core_rst_n) begin
         coreCnt     <= 0;
         core_done   <= 1'b0;
         core_hash   <= '0;
         launchBlock <= core_block;
      end else if (!core_done) begin
         if (coreCnt == LAT) begin
            core_done <= 1'b1;
            core_hash <= modelHash(blockNonce(core_block[31:0]));
            checkOutput("block_stable", 64'(core_block ^ launchBlock), 64'h0);
         end else begin
            coreCnt <= coreCnt + 1;
         end
      end
   end

   task automatic applyStimulus(input int mode, input bit holdStart);
      for (int k = 0; k < 76; k++) begin
         @(negedge clk);
         if (holdStart && k == 3) begin
            checkOutput("load_start_ignored_busy", busy, 1'b0);
            checkOutput("load_start_ignored_ready", in_ready, 1'b1);
         end
         in_valid = 1'b1;
         in_data  = (mode == 0) ? 8'(k) : 8'(k * 7 + 3);
         start    = holdStart && (k < 3);
      end
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic startSweep(input logic [31:0] init, input logic [255:0] tgt, input bit push);
      @(negedge clk);
      nonce_init = init;
      target     = tgt;
      start      = 1'b1;
      if (push) sb.push_back(predict(init, tgt));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finishSweep(input string tag);
      exp_t e;
      for (int i = 0; i < 2000 && !(found || exhausted); i++) @(negedge clk);
      checkOutput({tag, "_done"}, found | exhausted, 1'b1);
      if (sb.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         checkOutput({tag, "_found"}, found, e.fnd);
         checkOutput({tag, "_exhausted"}, exhausted, e.exh);
         checkOutput({tag, "_attempts"}, attempts, e.att);
         checkOutput({tag, "_busy"}, busy, 1'b0);
         if (e.fnd) checkOutput({tag, "_nonce"}, found_nonce, e.nonce);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
      checkOutput({tag, "_core_rst_n"}, core_rst_n, 1'b0);
      checkOutput({tag, "_busy"}, busy, 1'b0);
      checkOutput({tag, "_found"}, found, 1'b0);
      checkOutput({tag, "_exhausted"}, exhausted, 1'b0);
      checkOutput({tag, "_found_nonce"}, found_nonce, 32'h0);
      checkOutput({tag, "_attempts"}, attempts, 32'h0);
      checkOutput({tag, "_block_hi"}, core_block[639:576], 64'h0);
   endtask

   localparam logic [31:0] WIN = 32'h7C2B_AC1D;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h0; hdr_clear = 1'b0; start = 1'b0;
      abort = 1'b0; nonce_init = 32'h0; target = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkResetValues("reset");

      $display("[TB] load header 0x00..0x4B, all-ones target");
      applyStimulus(0, 1'b0);
      checkOutput("loaded_in_ready", in_ready, 1'b0);
      checkOutput("byte0", core_block[639:632], 8'h00);
      checkOutput("byte75", core_block[39:32], 8'h4B);
      startSweep(32'h0, {256{1'b1}}, 1'b1);
      finishSweep("allones");

      $display("[TB] hdr_clear in FOUND, reload with start held");
      @(negedge clk); hdr_clear = 1'b1;
      @(negedge clk); hdr_clear = 1'b0;
      checkOutput("clear_in_ready", in_ready, 1'b1);
      checkOutput("clear_found", found, 1'b0);
      applyStimulus(1, 1'b1);
      checkOutput("reload_in_ready", in_ready, 1'b0);
      checkOutput("reload_byte0", core_block[639:632], 8'h03);
      checkOutput("reload_byte75", core_block[39:32], 8'h10);

      $display("[TB] exhaust near top of nonce space");
      startSweep(32'hFFFF_FFFE, 256'h0, 1'b1);
      finishSweep("exhaust");
      checkOutput("no_wrap", blockNonce(core_block[31:0]), 32'hFFFF_FFFF);

      $display("[TB] hit two nonces past start");
      startSweep(WIN - 32'd2, {224'h0, ~WIN} + 256'd1, 1'b1);
      finishSweep("win");

      $display("[TB] equal hash is a miss");
      startSweep(WIN - 32'd1, {224'h0, ~WIN}, 1'b1);
      finishSweep("equal");

      $display("[TB] abort coincident with core_done");
      startSweep(32'd5, {256{1'b1}}, 1'b0);
      for (int i = 0; i < 200 && !core_done; i++) @(negedge clk);
      checkOutput("abort_saw_done", core_done, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_busy", busy, 1'b0);
      checkOutput("abort_found", found, 1'b0);
      checkOutput("abort_exhausted", exhausted, 1'b0);
      checkOutput("abort_attempts", attempts, 32'h0);
      checkOutput("abort_core_rst_n", core_rst_n, 1'b0);
      startSweep(32'd5, {256{1'b1}}, 1'b1);
      finishSweep("resume");

      $display("[TB] reset pulse mid-WAIT");
      startSweep(32'd9, 256'h0, 1'b0);
      for (int i = 0; i < 50 && !(busy && core_rst_n); i++) @(negedge clk);
      checkOutput("midwait_reached", core_rst_n, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      checkResetValues("midrst");
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_in_ready", in_ready, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
